// File: rtl/spi_ram_master_ctrl.sv
// SPI RAM master: turns one host request into an address frame plus a data frame.
// Optional build macro SPI_CTRL_ADDR_CACHE_EN skips the address frame on a repeated address.
module spi_ram_master_ctrl #(
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_TAIL,
    S_TURN,
    S_RX,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        data_phase;
  logic        rw_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [6:0]  rx_sh;
  logic [1:0]  cmd;
  logic [7:0]  payload;
  logic [10:0] frame;
  logic        hit;

`ifdef SPI_CTRL_ADDR_CACHE_EN
  logic [7:0] wr_cache_addr;
  logic [7:0] rd_cache_addr;
  logic       wr_cache_vld;
  logic       rd_cache_vld;

  // A hit means the slave already holds this address for this kind of access.
  always_comb begin
    hit = 1'b0;
    if (req_rw)
      hit = rd_cache_vld && (rd_cache_addr == req_addr);
    else
      hit = wr_cache_vld && (wr_cache_addr == req_addr);
  end

  // The cache is only committed once an address frame has fully gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cache_addr <= 8'h00;
      rd_cache_addr <= 8'h00;
      wr_cache_vld  <= 1'b0;
      rd_cache_vld  <= 1'b0;
    end else if (state == S_TAIL && !data_phase) begin
      if (rw_q) begin
        rd_cache_addr <= addr_q;
        rd_cache_vld  <= 1'b1;
      end else begin
        wr_cache_addr <= addr_q;
        wr_cache_vld  <= 1'b1;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Frame word is {cmd[1], cmd, payload}; cmd[0] marks the data frame.
  always_comb begin
    cmd = {rw_q, data_phase};
    if (!data_phase)
      payload = addr_q;
    else if (rw_q)
      payload = 8'h00;
    else
      payload = wdata_q;
    frame = {cmd[1], cmd, payload};
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    SS_n    = 1'b1;
    MOSI    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid)
          state_n = S_SEL;
      end
      S_SEL: begin
        SS_n    = 1'b0;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        SS_n = 1'b0;
        MOSI = frame[4'd10 - bit_cnt];
        if (bit_cnt == 4'd10)
          state_n = (data_phase && rw_q) ? S_TURN : S_TAIL;
      end
      S_TAIL: begin
        SS_n    = 1'b0;
        state_n = S_GAP;
      end
      S_TURN: begin
        SS_n    = 1'b0;
        state_n = S_RX;
      end
      S_RX: begin
        SS_n = 1'b0;
        if (bit_cnt == 4'd7)
          state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt <= 4'd1)
          state_n = data_phase ? S_IDLE : S_SEL;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: request capture, bit/gap counters and the MISO shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      gap_cnt    <= 4'd0;
      data_phase <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rx_sh      <= 7'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rw_q       <= req_rw;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            data_phase <= hit;
          end
        end
        S_SEL: bit_cnt <= 4'd0;
        S_SHIFT: begin
          if (bit_cnt == 4'd10)
            bit_cnt <= 4'd0;
          else
            bit_cnt <= bit_cnt + 4'd1;
        end
        S_TAIL: gap_cnt <= 4'(IDLE_GAP);
        S_TURN: bit_cnt <= 4'd0;
        S_RX: begin
          rx_sh <= {rx_sh[5:0], MISO};
          if (bit_cnt == 4'd7) begin
            rsp_rdata <= {rx_sh, MISO};
            rsp_valid <= 1'b1;
            gap_cnt   <= 4'(IDLE_GAP);
            bit_cnt   <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1)
            data_phase <= 1'b1;
        end
        default: bit_cnt <= 4'd0;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Bench for spi_ram_master_ctrl: two instances (IDLE_GAP 1 and 4) checked every cycle
// against a transaction-level schedule model, plus hand-computed latency/frame literals.
module tb_spi_ram_master_ctrl;

`ifdef SPI_CTRL_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       miso0, miso1;
  logic       ready0, rspv0, busy0, ss0, mosi0;
  logic       ready1, rspv1, busy1, ss1, mosi1;
  logic [7:0] rdata0, rdata1;

  always #5 clk = ~clk;

  spi_ram_master_ctrl #(.IDLE_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv0), .rsp_rdata(rdata0), .busy(busy0),
    .SS_n(ss0), .MOSI(mosi0), .MISO(miso0));

  spi_ram_master_ctrl #(.IDLE_GAP(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv1), .rsp_rdata(rdata1), .busy(busy1),
    .SS_n(ss1), .MOSI(mosi1), .MISO(miso1));

  // One entry per clock cycle of a transaction; an empty queue means idle.
  typedef struct packed {
    logic       ss_n;
    logic       mosi;
    logic       rx;
    logic       miso;
    logic       rsp;
    logic [7:0] rdata;
    logic       upd;
    logic       upd_rw;
    logic [7:0] upd_addr;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] ram [2][256];
  logic [7:0] last_rd [2];
  logic       wc_v [2];
  logic       rc_v [2];
  logic [7:0] wc_a [2];
  logic [7:0] rc_a [2];
  int         accepts [2];
  int         checks = 0;
  int         errors = 0;
  bit         run = 1'b0;
  int         starts0 = 0;
  logic       busy0_d = 1'b0;
  int         cycle = 0;

  logic       rec_ss   [64];
  logic       rec_mosi [64];
  logic       rec_rdy  [64];
  logic       rec_rsp  [64];
  logic [7:0] rec_rd   [64];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic addFrame(input int d, input logic [10:0] w, input bit rd_data,
                          input logic [7:0] rdata, input int gap, input bit upd,
                          input bit upd_rw, input logic [7:0] upd_addr);
    exp_t e;
    e = '0;
    pushExp(d, e);
    for (int i = 10; i >= 0; i--) begin
      e = '0;
      e.mosi = w[i];
      pushExp(d, e);
    end
    if (rd_data) begin
      e = '0;
      pushExp(d, e);
      for (int i = 7; i >= 0; i--) begin
        e = '0;
        e.rx = 1'b1;
        e.miso = rdata[i];
        pushExp(d, e);
      end
    end else begin
      e = '0;
      e.upd = upd;
      e.upd_rw = upd_rw;
      e.upd_addr = upd_addr;
      pushExp(d, e);
    end
    for (int g = 0; g < gap; g++) begin
      e = '0;
      e.ss_n = 1'b1;
      if (g == 0 && rd_data) begin
        e.rsp = 1'b1;
        e.rdata = rdata;
      end
      pushExp(d, e);
    end
  endtask

  task automatic modelAccept(input int d, input int gap);
    bit hit;
    hit = CACHE_EN && (req_rw ? (rc_v[d] && rc_a[d] == req_addr)
                              : (wc_v[d] && wc_a[d] == req_addr));
    if (!hit)
      addFrame(d, {req_rw, req_rw, 1'b0, req_addr}, 1'b0, 8'h00, gap, 1'b1, req_rw, req_addr);
    if (req_rw) begin
      addFrame(d, {3'b111, 8'h00}, 1'b1, ram[d][req_addr], gap, 1'b0, 1'b0, 8'h00);
    end else begin
      addFrame(d, {3'b001, req_wdata}, 1'b0, 8'h00, gap, 1'b0, 1'b0, 8'h00);
      ram[d][req_addr] = req_wdata;
    end
  endtask

  task automatic cmpDut(input int d, input int gap, input logic ss, input logic mo,
                        input logic rdy, input logic bz, input logic rv, input logic [7:0] rd);
    exp_t e;
    bit   idle;
    logic m;
    idle = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (idle) begin
      e = '0;
      e.ss_n = 1'b1;
    end else if (d == 0) begin
      e = q0.pop_front();
    end else begin
      e = q1.pop_front();
    end
    if (e.rsp) last_rd[d] = e.rdata;
    checkOutput($sformatf("dut%0d_ss_n", d), {7'd0, ss}, {7'd0, e.ss_n});
    checkOutput($sformatf("dut%0d_mosi", d), {7'd0, mo}, {7'd0, e.mosi});
    checkOutput($sformatf("dut%0d_req_ready", d), {7'd0, rdy}, {7'd0, idle});
    checkOutput($sformatf("dut%0d_busy", d), {7'd0, bz}, {7'd0, !idle});
    checkOutput($sformatf("dut%0d_rsp_valid", d), {7'd0, rv}, {7'd0, e.rsp});
    checkOutput($sformatf("dut%0d_rsp_rdata", d), rd, last_rd[d]);
    m = e.rx ? e.miso : 1'($urandom);
    if (d == 0) miso0 = m;
    else        miso1 = m;
    if (rst) begin
      if (d == 0) q0.delete();
      else        q1.delete();
      last_rd[d] = 8'h00;
      wc_v[d] = 1'b0;
      rc_v[d] = 1'b0;
    end else begin
      if (e.upd) begin
        if (e.upd_rw) begin rc_v[d] = 1'b1; rc_a[d] = e.upd_addr; end
        else          begin wc_v[d] = 1'b1; wc_a[d] = e.upd_addr; end
      end
      if (idle && req_valid) begin
        modelAccept(d, gap);
        accepts[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (busy0 && !busy0_d) starts0++;
    busy0_d = busy0;
    if (run) begin
      cmpDut(0, 1, ss0, mosi0, ready0, busy0, rspv0, rdata0);
      cmpDut(1, 4, ss1, mosi1, ready1, busy1, rspv1, rdata1);
    end
    if (cycle > 20000) begin
      errors++;
      $display("[TB] FAIL watchdog got cycle %0d want below 20000", cycle);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  function automatic bit bothIdle();
    return (q0.size() == 0) && (q1.size() == 0);
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bothIdle() && n < 500);
    if (!bothIdle()) checkOutput("wait_idle_timeout", 8'd1, 8'd0);
  endtask

  task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic holdRequest(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
    int b0, b1, n;
    @(posedge clk); #1;
    b0 = accepts[0];
    b1 = accepts[1];
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(accepts[0] > b0 && accepts[1] > b1) && n < 300);
    req_valid = 1'b0;
    if (n >= 300) checkOutput("hold_accept_timeout", 8'd1, 8'd0);
  endtask

  // Records cycles 1..n after an acceptance (call straight after applyStimulus).
  task automatic recordDut(input int d, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_ss[k]   = (d == 0) ? ss0 : ss1;
      rec_mosi[k] = (d == 0) ? mosi0 : mosi1;
      rec_rdy[k]  = (d == 0) ? ready0 : ready1;
      rec_rsp[k]  = (d == 0) ? rspv0 : rspv1;
      rec_rd[k]   = (d == 0) ? rdata0 : rdata1;
    end
  endtask

  function automatic logic [10:0] frameAt(input int start);
    logic [10:0] w;
    for (int i = 0; i < 11; i++) w[10 - i] = rec_mosi[start + i];
    return w;
  endfunction

  initial begin
    int s;
    rst = 1'b1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    miso0 = 1'b0;
    miso1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) ram[d][i] = 8'(i) ^ 8'h5A;
      ram[d][8'hFC] = 8'h3C;
      ram[d][8'h42] = 8'h96;
      last_rd[d] = 8'h00;
      wc_v[d] = 1'b0;
      rc_v[d] = 1'b0;
      wc_a[d] = 8'h00;
      rc_a[d] = 8'h00;
      accepts[d] = 0;
    end

    @(posedge clk); @(negedge clk);
    checkOutput("reset_ss_n", {7'd0, ss0}, 8'd1);
    checkOutput("reset_mosi", {7'd0, mosi0}, 8'd0);
    checkOutput("reset_ready", {7'd0, ready0}, 8'd1);
    checkOutput("reset_busy", {7'd0, busy0}, 8'd0);
    checkOutput("reset_rsp_valid", {7'd0, rspv0}, 8'd0);
    checkOutput("reset_rdata", rdata0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b1;

    $display("[TB] write FD/FC");
    waitIdle();
    applyStimulus(1'b0, 8'hFD, 8'hFC);
    recordDut(0, 30);
    checkOutput("wr_frame_addr", 8'(frameAt(2) >> 3), 8'(11'b0_00_11111101 >> 3));
    checkOutput("wr_frame_addr_lo", {5'd0, frameAt(2)[2:0]}, 8'b101);
    checkOutput("wr_frame_data", frameAt(16)[7:0], 8'hFC);
    checkOutput("wr_frame_data_cmd", {5'd0, frameAt(16)[10:8]}, 8'b001);
    checkOutput("wr_ss_c1", {7'd0, rec_ss[1]}, 8'd0);
    checkOutput("wr_ss_c13", {7'd0, rec_ss[13]}, 8'd0);
    checkOutput("wr_ss_c14", {7'd0, rec_ss[14]}, 8'd1);
    checkOutput("wr_ss_c15", {7'd0, rec_ss[15]}, 8'd0);
    checkOutput("wr_ss_c28", {7'd0, rec_ss[28]}, 8'd1);
    checkOutput("wr_ready_c28", {7'd0, rec_rdy[28]}, 8'd0);
    checkOutput("wr_ready_c29", {7'd0, rec_rdy[29]}, 8'd1);

    $display("[TB] read FC");
    waitIdle();
    applyStimulus(1'b1, 8'hFC, 8'h00);
    recordDut(0, 38);
    checkOutput("rd_frame_addr", frameAt(2)[7:0], 8'hFC);
    checkOutput("rd_frame_addr_cmd", {5'd0, frameAt(2)[10:8]}, 8'b110);
    checkOutput("rd_frame_data", frameAt(16)[7:0], 8'h00);
    checkOutput("rd_frame_data_cmd", {5'd0, frameAt(16)[10:8]}, 8'b111);
    checkOutput("rd_ss_c35", {7'd0, rec_ss[35]}, 8'd0);
    checkOutput("rd_rsp_c35", {7'd0, rec_rsp[35]}, 8'd0);
    checkOutput("rd_rsp_c36", {7'd0, rec_rsp[36]}, 8'd1);
    checkOutput("rd_rsp_c37", {7'd0, rec_rsp[37]}, 8'd0);
    checkOutput("rd_rdata_c36", rec_rd[36], 8'h3C);
    checkOutput("rd_ready_c36", {7'd0, rec_rdy[36]}, 8'd0);
    checkOutput("rd_ready_c37", {7'd0, rec_rdy[37]}, 8'd1);

    $display("[TB] request held during busy write");
    waitIdle();
    s = starts0;
    applyStimulus(1'b0, 8'hA0, 8'h11);
    repeat (4) @(posedge clk);
    holdRequest(1'b1, 8'hA0, 8'h00);
    waitIdle();
    checkOutput("held_starts_dut1", 8'(starts0 - s), 8'd2);
    checkOutput("held_rdata_dut1", rdata0, 8'h11);

    $display("[TB] reset in the middle of a read");
    waitIdle();
    s = starts0;
    applyStimulus(1'b1, 8'hFC, 8'h00);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ss_n", {7'd0, ss0}, 8'd1);
    checkOutput("abort_mosi", {7'd0, mosi0}, 8'd0);
    checkOutput("abort_ready", {7'd0, ready0}, 8'd1);
    checkOutput("abort_rdata", rdata0, 8'h00);
    waitIdle();
    applyStimulus(1'b1, 8'h42, 8'h00);
    recordDut(0, 37);
    checkOutput("rerd_frame_addr", frameAt(2)[7:0], 8'h42);
    checkOutput("rerd_frame_addr_cmd", {5'd0, frameAt(2)[10:8]}, 8'b110);
    checkOutput("rerd_rsp_c36", {7'd0, rec_rsp[36]}, 8'd1);
    checkOutput("rerd_rdata_c36", rec_rd[36], 8'h96);

    $display("[TB] IDLE_GAP=4 write then back-to-back read");
    waitIdle();
    applyStimulus(1'b0, 8'h33, 8'h77);
    recordDut(1, 34);
    checkOutput("gap4_ss_c13", {7'd0, rec_ss[13]}, 8'd0);
    checkOutput("gap4_ss_c14", {7'd0, rec_ss[14]}, 8'd1);
    checkOutput("gap4_ss_c17", {7'd0, rec_ss[17]}, 8'd1);
    checkOutput("gap4_ss_c18", {7'd0, rec_ss[18]}, 8'd0);
    checkOutput("gap4_frame_data", frameAt(19)[7:0], 8'h77);
    checkOutput("gap4_ready_c34", {7'd0, rec_rdy[34]}, 8'd0);
    applyStimulus(1'b1, 8'h33, 8'h00);
    waitIdle();
    checkOutput("gap4_rdata", rdata1, 8'h77);

    $display("[TB] directed vectors and repeated addresses");
    applyStimulus(1'b0, 8'h55, 8'hAA); waitIdle();
    applyStimulus(1'b1, 8'h55, 8'h00); waitIdle();
    applyStimulus(1'b0, 8'h00, 8'hFF); waitIdle();
    applyStimulus(1'b1, 8'h00, 8'h00); waitIdle();
    applyStimulus(1'b1, 8'hFF, 8'h00); waitIdle();
    applyStimulus(1'b0, 8'h10, 8'hAB); waitIdle();
    applyStimulus(1'b0, 8'h10, 8'hCD); waitIdle();
    applyStimulus(1'b1, 8'h10, 8'h00); waitIdle();
    applyStimulus(1'b1, 8'h10, 8'h00); waitIdle();
    checkOutput("final_rdata_dut1", rdata0, 8'hCD);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
